// File: rtl/dct8_bfly_stage.sv
// First butterfly stage of the 8-point DCT: buffers one 8-sample frame, then
// streams 4 sums and 4 differences, each saturated or wrapped back to WIDTH.
module dct8_bfly_stage #(
  parameter int WIDTH  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_sat
);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       in_cnt;
  logic [2:0]       out_idx;
  logic             issued;
  logic [WIDTH-1:0] samples [8];

  logic             accept, load, take_last;
  logic [2:0]       ia, ib;
  logic [WIDTH:0]   opa, opb, res;
  logic             ovf;
  logic [WIDTH-1:0] res_data;

  assign in_ready = (state == LOAD);

  always_comb begin
    accept    = in_valid && in_ready;
    load      = (state == EMIT) && !issued && (!out_valid || out_ready);
    take_last = out_valid && out_ready && out_last;
    state_nxt = state;
    case (state)
      LOAD: if (accept && in_cnt == 3'd7) state_nxt = EMIT;
      EMIT: if (take_last)                state_nxt = LOAD;
    endcase
  end

  // k and k+4 share the same operand pair: buf[k mod 4] and buf[7 - k mod 4]
  always_comb begin
    ia  = {1'b0, out_idx[1:0]};
    ib  = ~ia;
    opa = {samples[ia][WIDTH-1], samples[ia]};
    opb = {samples[ib][WIDTH-1], samples[ib]};
    res = out_idx[2] ? (opa - opb) : (opa + opb);
    ovf = res[WIDTH] != res[WIDTH-1];
    if (ovf && SAT_EN)
      res_data = res[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_data = res[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept) samples[in_cnt] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      in_cnt    <= '0;
      out_idx   <= '0;
      issued    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) in_cnt <= in_cnt + 3'd1;
      if (load) begin
        out_data  <= res_data;
        out_sat   <= ovf;
        out_last  <= (out_idx == 3'd7);
        out_valid <= 1'b1;
        out_idx   <= out_idx + 3'd1;
        if (out_idx == 3'd7) issued <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // issued marks y[7] already loaded so the wrapped out_idx is not reissued
      if (take_last) begin
        issued  <= 1'b0;
        out_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dct8_bfly_stage.sv
// Randomized bench for dct8_bfly_stage: saturating and wrapping instances are
// checked every cycle against a frame-level butterfly model.
module tb_dct8_bfly_stage;
  localparam int W    = 16;
  localparam int MAXV = (1 <<< (W-1)) - 1;
  localparam int MINV = -(1 <<< (W-1));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, in_ready_w;
  logic [W-1:0] out_data, out_data_w;
  logic         out_valid, out_valid_w, out_last, out_last_w, out_sat, out_sat_w;

  dct8_bfly_stage #(.WIDTH(W), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_sat(out_sat));

  dct8_bfly_stage #(.WIDTH(W), .SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w),
    .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_last(out_last_w), .out_sat(out_sat_w));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int ds; int dw; bit sat; bit last; } exp_t;
  exp_t expq[$];
  int   mx[8];
  int   mcnt = 0;
  bit   busy = 1'b0;
  int   busy_cyc = 0;

  function automatic int clampv(input int s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  function automatic int wrapv(input int s);
    logic [31:0] u;
    u = s;
    return int'($signed(u[W-1:0]));
  endfunction

  function automatic void build();
    for (int k = 0; k < 8; k++) begin
      int s;
      exp_t e;
      s = (k < 4) ? mx[k] + mx[7-k] : mx[k-4] - mx[11-k];
      e.ds = clampv(s); e.dw = wrapv(s);
      e.sat = (s > MAXV) || (s < MINV); e.last = (k == 7);
      expq.push_back(e);
    end
  endfunction

  // ---------------- compare process ----------------
  bit acc_in = 0, end_flag = 0, prev_stall = 0;
  int acc_data;
  int held_d, held_dw, held_l, held_s;
  int obs[$];
  int obs_sat[$];
  int n_taken = 0;

  always @(negedge clk) begin
    acc_in = 0; end_flag = 0;
    if (rst) prev_stall = 0;
    else begin
      check("in_ready", int'(in_ready), int'(!busy));
      check("in_ready_w", int'(in_ready_w), int'(!busy));
      check("out_valid", int'(out_valid), int'(busy && busy_cyc >= 1));
      check("out_valid_w", int'(out_valid_w), int'(busy && busy_cyc >= 1));
      if (prev_stall) begin
        check("hold_data", int'($signed(out_data)), held_d);
        check("hold_data_w", int'($signed(out_data_w)), held_dw);
        check("hold_last", int'(out_last), held_l);
        check("hold_sat", int'(out_sat), held_s);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL extra_output: got data %0d, expected no output", $signed(out_data));
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("data_sat", int'($signed(out_data)), e.ds);
          check("data_wrap", int'($signed(out_data_w)), e.dw);
          check("sat_flag", int'(out_sat), int'(e.sat));
          check("sat_flag_w", int'(out_sat_w), int'(e.sat));
          check("last", int'(out_last), int'(e.last));
          check("last_w", int'(out_last_w), int'(e.last));
          end_flag = e.last;
        end
        obs.push_back(int'($signed(out_data)));
        obs_sat.push_back(int'(out_sat));
        n_taken++;
      end
      prev_stall = out_valid && !out_ready;
      held_d = int'($signed(out_data)); held_dw = int'($signed(out_data_w));
      held_l = int'(out_last); held_s = int'(out_sat);
      acc_in = in_valid && !busy;
      acc_data = int'($signed(in_data));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      busy = 0; mcnt = 0; busy_cyc = 0; expq.delete();
    end else begin
      if (busy) begin
        busy_cyc++;
        if (end_flag) busy = 0;
      end
      if (acc_in) begin
        mx[mcnt] = acc_data;
        mcnt++;
        if (mcnt == 8) begin
          build(); busy = 1; busy_cyc = 0; mcnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] src[$];
  int iv_mode = 0, or_mode = 0, cyc = 0;
  bit bp_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int ramp_y[8] = '{9, 9, 9, 9, -7, -5, -3, -1};

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (acc && src.size() > 0) void'(src.pop_front());
    cyc++;
    case (iv_mode)
      0:       in_valid = src.size() > 0;
      1:       in_valid = (cyc % 2 == 0) && src.size() > 0;
      default: in_valid = ($urandom_range(0, 2) != 0) && src.size() > 0;
    endcase
    in_data = (src.size() > 0) ? src[0] : W'($urandom);
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = bp_pat[cyc % 6];
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((src.size() > 0 || busy || expq.size() > 0) && n < maxc) begin
      step(); n++;
    end
    if (n >= maxc) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", expq.size());
    end
  endtask

  function automatic logic [W-1:0] rnd_sample();
    case ($urandom_range(0, 5))
      0:       return W'(MAXV);
      1:       return W'(MINV);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic push_ramp();
    for (int i = 1; i <= 8; i++) src.push_back(W'(i));
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_count"}, obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      check({tag, "_y"}, obs[i], ramp_y[i]);
      check({tag, "_sat"}, obs_sat[i], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // pin the model with hand-computed values
    for (int i = 0; i < 8; i++) mx[i] = i + 1;
    build();
    for (int i = 0; i < 8; i++) check("model_ramp", expq[i].ds, ramp_y[i]);
    expq.delete();
    mx = '{32767, 3, 4, 5, 6, 7, 8, 1};
    build();
    check("model_sat_y0", expq[0].ds, 32767);
    check("model_wrap_y0", expq[0].dw, -32768);
    check("model_sat_flag", int'(expq[0].sat), 1);
    expq.delete();
    mcnt = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // ramp, no backpressure
    obs.delete(); obs_sat.delete();
    push_ramp();
    drain(100);
    check_ramp("ramp");

    // saturation / wrap on y0
    obs.delete(); obs_sat.delete();
    src.push_back(W'(MAXV));
    for (int i = 0; i < 6; i++) src.push_back(W'(i * 10));
    src.push_back(W'(1));
    drain(100);
    check("satpos_y0", obs[0], 32767);
    check("satpos_y0_flag", obs_sat[0], 1);
    check("satpos_y4", obs[4], 32766);
    check("satpos_y4_flag", obs_sat[4], 0);

    // saturation / wrap on y4
    obs.delete(); obs_sat.delete();
    src.push_back(W'(MINV));
    for (int i = 0; i < 6; i++) src.push_back(W'(i));
    src.push_back(W'(1));
    drain(100);
    check("satneg_y4", obs[4], -32768);
    check("satneg_y4_flag", obs_sat[4], 1);
    check("satneg_y0", obs[0], -32767);

    // input gaps and backpressure, back-to-back frames
    iv_mode = 1; or_mode = 1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 8; i++) src.push_back(rnd_sample());
    drain(600);

    // reset after y[2] is accepted
    iv_mode = 0; or_mode = 0;
    push_ramp();
    begin
      int target, n;
      target = n_taken + 3; n = 0;
      while (n_taken < target && n < 100) begin step(); n++; end
      if (n >= 100) begin
        vectors++; miscompares++;
        $display("FAIL reset_wait: got %0d outputs, expected %0d", n_taken, target);
      end
    end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    src.delete();
    obs.delete(); obs_sat.delete();
    push_ramp();
    drain(100);
    check_ramp("post_rst");

    // fully random traffic
    iv_mode = 2; or_mode = 2;
    for (int f = 0; f < 20; f++)
      for (int i = 0; i < 8; i++) src.push_back(rnd_sample());
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dct8_bfly_stage.md
# dct8_bfly_stage

First butterfly stage of the memory-based 8-point DCT datapath. Collects one 8-sample frame from a streaming valid/ready input into an internal buffer. Emits the 8 first-stage butterfly results (4 sums, then 4 differences) as a valid/ready stream that feeds the safe-scaling unit (`ss_unit`) directly. Each sum and difference is formed at WIDTH+1 bits, then saturated (or wrapped) back to WIDTH.

## Interface
- WIDTH, 16 — sample width; input and output samples are signed two's complement.
- SAT_EN, 1 — 1: clamp overflowing results to the WIDTH range; 0: wrap (keep low WIDTH bits).
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — reset; asynchronous, active-high.
- in_data  in  WIDTH  — signed input sample x[n], n = 0..7 in arrival order.
- in_valid  in  1  — in_data is valid.
- in_ready  out  1  — block accepts a sample; a sample is accepted on an edge where in_valid && in_ready.
- out_data  out  WIDTH  — signed butterfly result y[k].
- out_valid  out  1  — out_data, out_last and out_sat are valid.
- out_ready  in  1  — downstream accepts; an output is taken on an edge where out_valid && out_ready.
- out_last  out  1  — high with y[7], the final result of the frame.
- out_sat  out  1  — the WIDTH+1-bit result of this y[k] fell outside the WIDTH range.

## Operation
- States: LOAD and EMIT.
- LOAD:
  - in_ready = 1.
  - Each accepted sample is written to buf[in_cnt], then in_cnt increments (3-bit counter).
  - The accept with in_cnt == 7 sets in_cnt to 0 and moves the state to EMIT.
- EMIT:
  - in_ready = 0; in_valid is ignored.
  - The 3-bit out_idx counter walks k = 0..7.
  - k = 0..3: y[k] = buf[k] + buf[7-k].
  - k = 4..7: y[k] = buf[k-4] - buf[11-k].
- Output register: out_data, out_valid, out_last and out_sat are registers. They load y[out_idx] when state == EMIT, out_idx has not yet been issued, and (!out_valid || out_ready). out_idx increments on each such load.
- Holding: while out_valid && !out_ready, all four output registers hold.
- Frame end: on the edge where y[7] is accepted:
  - out_valid clears, unless a new y[0] is loading on the same edge, which cannot happen in a single-buffer design.
  - The state returns to LOAD.
  - out_idx returns to 0.
- Arithmetic: sign-extend both operands to WIDTH+1 bits, then add or subtract. Overflow means result > 2^(WIDTH-1)-1 or < -2^(WIDTH-1).
  - On overflow, out_sat = 1.
  - With SAT_EN = 1, out_data is clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - With SAT_EN = 0, out_data is the low WIDTH bits.
  - Without overflow, out_sat = 0 and out_data is the exact result.
- Reset (any time, including mid-LOAD or mid-EMIT):
  - state = LOAD; in_cnt = 0; out_idx = 0.
  - out_valid = 0; out_data = 0; out_last = 0; out_sat = 0.
  - in_ready therefore reads 1.
  - The buffer contents are don't-care; a partial frame is discarded.

## Timing
- Input: up to 1 sample per cycle; in_valid gaps are allowed and stall in_cnt.
- Latency: the 8th input is accepted at edge E; the state is EMIT after E; out_valid = 1 with y[0] after edge E+1.
- Output: 1 result per cycle while out_ready = 1; y[0..7] occupy 8 consecutive cycles under no backpressure.
- Backpressure: out_valid, once high, stays high until accepted. out_data, out_last and out_sat are stable while stalled.
- in_ready is low from the edge after the 8th input accept until the edge after y[7] is accepted.
- Minimum frame period: 8 (LOAD) + 1 (pipeline) + 8 (EMIT) = 17 cycles.

## Test plan
- Ramp: x = 1,2,3,4,5,6,7,8 with out_ready = 1.
  - y = 9,9,9,9,-7,-5,-3,-1; out_sat = 0 throughout.
  - out_last only on -1.
  - out_valid first rises 2 edges after the 8th accept.
- Saturation (WIDTH=16, SAT_EN=1):
  - x0 = 32767, x7 = 1 → y0 = 32767 with out_sat = 1.
  - x0 = -32768, x7 = 1 → y4 = -32768 with out_sat = 1.
  - The other outputs are exact, with out_sat = 0.
- Wrap (SAT_EN=0): x0 = 32767, x7 = 1 → y0 = -32768 with out_sat = 1.
- Backpressure: out_ready follows 1,0,0,1,0,1,...
  - All 8 results arrive in order, with none lost or duplicated.
  - Outputs are held stable on stall cycles.
  - in_ready stays 0 until y[7] is accepted.
- Input gaps: in_valid high only on alternate cycles, with in_valid also asserted during EMIT.
  - Exactly 8 samples are captured per frame.
  - Samples presented during EMIT are not consumed (in_ready = 0).
  - A second back-to-back frame produces correct results.
- Reset after y[2] is accepted:
  - Next cycle: out_valid = 0, out_data = 0, in_ready = 1.
  - A following ramp frame yields 9,9,9,9,-7,-5,-3,-1.
